// File: rtl/ssp_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ssp_host_arbiter
// Purpose  : Shares the SSP parallel bus port between two byte requesters
//            (round-robin TX bursts) and drains the RX FIFO in bursts.
// Revision : 1.0 - initial release
// ============================================================================
module ssp_host_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic       pclk,
    input  logic       clr,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       ssptxintr,
    input  logic       ssprxintr,
    input  logic [7:0] prdata,
    output logic       psel,
    output logic       pwrite,
    output logic [7:0] pwdata,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int             c_CW        = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TXBURST   = 3'd1,
        S_RD_STROBE = 3'd2,
        S_RD_WAIT   = 3'd3,
        S_RD_HOLD   = 3'd4
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [c_CW-1:0] r_count,      w_count_nxt;
    logic [1:0]      r_grant,      w_grant_nxt;
    logic            r_last_grant, w_last_grant_nxt;   // 1 = requester 1 owned the last burst
    logic            r_rx_valid,   w_rx_valid_nxt;
    logic [7:0]      r_rx_data,    w_rx_data_nxt;

    logic            w_gvalid;
    logic [7:0]      w_gdata;
    logic            w_pick1;
    logic [c_CW-1:0] w_count_inc;

    assign w_gvalid    = r_grant[0] ? req0_valid : req1_valid;
    assign w_gdata     = r_grant[0] ? req0_data  : req1_data;
    // Under contention the requester that did not own the previous burst wins.
    assign w_pick1     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_count_inc = r_count + c_ONE;

    always_ff @(posedge pclk or posedge clr) begin
        if (clr) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_data    <= w_rx_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_rx_valid_nxt   = r_rx_valid;
        w_rx_data_nxt    = r_rx_data;
        psel             = 1'b0;
        pwrite           = 1'b0;
        pwdata           = 8'h00;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ssprxintr) begin
                    w_state_nxt = S_RD_STROBE;
                    w_count_nxt = '0;
                end else if (ssptxintr && (req0_valid || req1_valid)) begin
                    w_state_nxt      = S_TXBURST;
                    w_count_nxt      = '0;
                    w_grant_nxt      = w_pick1 ? 2'b10 : 2'b01;
                    w_last_grant_nxt = w_pick1;
                end
            end

            S_TXBURST: begin
                if (w_gvalid) begin
                    psel        = 1'b1;
                    pwrite      = 1'b1;
                    pwdata      = w_gdata;
                    req0_ready  = r_grant[0];
                    req1_ready  = r_grant[1];
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_DEPTH_CNT) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    // Requester went quiet: forfeit the remainder of the burst.
                    w_state_nxt = S_IDLE;
                end
            end

            S_RD_STROBE: begin
                psel        = 1'b1;
                w_state_nxt = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                w_rx_data_nxt  = prdata;
                w_rx_valid_nxt = 1'b1;
                w_count_nxt    = w_count_inc;
                w_state_nxt    = S_RD_HOLD;
            end

            S_RD_HOLD: begin
                if (rx_ready) begin
                    w_rx_valid_nxt = 1'b0;
                    w_state_nxt    = (r_count < c_DEPTH_CNT) ? S_RD_STROBE : S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign grant    = (r_state == S_TXBURST) ? r_grant : 2'b00;
    assign busy     = (r_state != S_IDLE);
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_ssp_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssp_host_arbiter
// Purpose  : Scoreboard bench for ssp_host_arbiter with requester/SSP models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssp_host_arbiter;

    localparam int DEPTH = 4;

    logic       pclk = 1'b0;
    logic       clr  = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       ssptxintr = 1'b0, ssprxintr = 1'b0;
    logic [7:0] prdata = 8'h00;
    logic       psel, pwrite;
    logic [7:0] pwdata;
    logic [1:0] grant;
    logic       busy;

    always #5 pclk = ~pclk;

    ssp_host_arbiter #(.DEPTH(DEPTH)) dut (
        .pclk(pclk), .clr(clr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .ssptxintr(ssptxintr), .ssprxintr(ssprxintr), .prdata(prdata),
        .psel(psel), .pwrite(pwrite), .pwdata(pwdata), .grant(grant), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_lo = -1, stall_hi = -1;
    bit en0 = 0, en1 = 0, rd_pend = 0;
    logic [7:0] q0[$], q1[$], rx_src[$], exp_r[$];
    logic [9:0] exp_w[$];   // {grant, byte}

    // Requester and SSP RX models; inputs change just after the falling edge.
    task automatic drive();
        req0_valid = en0 && (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        req1_valid = en1 && (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
        rx_ready   = !(cyc >= stall_lo && cyc <= stall_hi);
        if (rd_pend) begin
            if (rx_src.size() > 0) prdata = rx_src.pop_front();
            else                   prdata = 8'hEE;
            rd_pend = 0;
        end
    endtask

    task automatic step();
        @(negedge pclk);
        cyc++;
        drive();
        #1;
        if (req0_ready) void'(q0.pop_front());
        if (req1_ready) void'(q1.pop_front());
        if (psel && !pwrite) rd_pend = 1;
    endtask

    task automatic clear_models();
        q0.delete(); q1.delete(); rx_src.delete(); exp_r.delete(); exp_w.delete();
        en0 = 0; en1 = 0; rd_pend = 0; stall_lo = -1; stall_hi = -1;
        ssptxintr = 0; ssprxintr = 0;
    endtask

    task automatic test_reset();
        int writes = 0, first = -1;
        logic [9:0] e;
        clr = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            req0_data = 8'($urandom); req1_data = 8'($urandom);
            ssptxintr = 1'($urandom); ssprxintr = 1'($urandom);
            rx_ready = 1'($urandom); prdata = 8'($urandom);
            #1;
            n_cmp++;
            if ({psel, pwrite, pwdata, req0_ready, req1_ready, rx_valid, rx_data, grant, busy} !== 25'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got psel=%b pwrite=%b pwdata=%h rdy=%b%b rx_valid=%b rx_data=%h grant=%b busy=%b, want all 0",
                         psel, pwrite, pwdata, req1_ready, req0_ready, rx_valid, rx_data, grant, busy);
            end
        end
        clear_models();
        for (int i = 0; i < DEPTH; i++) begin
            q0.push_back(8'hA1 + 8'(i));
            exp_w.push_back({2'b01, 8'hA1 + 8'(i)});
        end
        en0 = 1; ssptxintr = 1; cyc = 0; clr = 0;
        drive();
        for (int i = 0; i < 20 && writes < DEPTH; i++) begin
            step();
            if (psel && pwrite) begin
                writes++;
                if (first < 0) first = cyc;
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_err++; $display("FAIL single_write: unexpected write grant=%b data=%h", grant, pwdata);
                end else begin
                    e = exp_w.pop_front();
                    if ({grant, pwdata} !== e) begin
                        n_err++; $display("FAIL single_write: got grant=%b data=%h, want grant=%b data=%h", grant, pwdata, e[9:8], e[7:0]);
                    end
                end
            end
        end
        ssptxintr = 0;
        n_cmp++;
        if (writes != DEPTH) begin n_err++; $display("FAIL single_count: got %0d writes, want %0d", writes, DEPTH); end
        n_cmp++;
        if (first != 1) begin n_err++; $display("FAIL single_latency: first write at cycle %0d, want 1", first); end
        step();
        n_cmp++;
        if (busy !== 1'b0 || psel !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b psel=%b, want 0 0", busy, psel); end
        clear_models(); drive();
    endtask

    task automatic test_early_end();
        int writes = 0;
        logic [9:0] e;
        q1.push_back(8'h55); q1.push_back(8'h66);
        exp_w.push_back({2'b10, 8'h55}); exp_w.push_back({2'b10, 8'h66});
        en1 = 1; ssptxintr = 1; cyc = 0;
        drive();
        for (int i = 0; i < 10 && writes < 2; i++) begin
            step();
            if (psel && pwrite) begin
                writes++;
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_err++; $display("FAIL early_write: unexpected write grant=%b data=%h", grant, pwdata);
                end else begin
                    e = exp_w.pop_front();
                    if ({grant, pwdata} !== e || {req1_ready, req0_ready} !== 2'b10) begin
                        n_err++; $display("FAIL early_write: got grant=%b data=%h rdy=%b%b, want grant=%b data=%h rdy=10",
                                          grant, pwdata, req1_ready, req0_ready, e[9:8], e[7:0]);
                    end
                end
            end
        end
        n_cmp++;
        if (writes != 2) begin n_err++; $display("FAIL early_count: got %0d writes, want 2", writes); end
        step();
        n_cmp++;
        if (psel !== 1'b0) begin n_err++; $display("FAIL early_nowrite: got psel=%b, want 0", psel); end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL early_idle: got busy=%b, want 0", busy); end
        clear_models(); drive();
    endtask

    task automatic test_contention();
        int writes = 0, last = -1;
        logic [9:0] e;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'hC0 + 8'(i));
            q1.push_back(8'hD0 + 8'(i));
        end
        for (int i = 0; i < DEPTH; i++) exp_w.push_back({2'b01, 8'hC0 + 8'(i)});
        for (int i = 0; i < DEPTH; i++) exp_w.push_back({2'b10, 8'hD0 + 8'(i)});
        for (int i = 0; i < DEPTH; i++) exp_w.push_back({2'b01, 8'hC4 + 8'(i)});
        en0 = 1; en1 = 1; ssptxintr = 1; cyc = 0;
        drive();
        for (int i = 0; i < 40 && writes < 3 * DEPTH; i++) begin
            step();
            if (psel && pwrite) begin
                writes++;
                last = cyc;
                n_cmp++;
                if (exp_w.size() == 0) begin
                    n_err++; $display("FAIL contention_write: unexpected write grant=%b data=%h", grant, pwdata);
                end else begin
                    e = exp_w.pop_front();
                    if ({grant, pwdata} !== e || {req1_ready, req0_ready} !== e[9:8]) begin
                        n_err++; $display("FAIL contention_write: got grant=%b data=%h rdy=%b%b, want grant=%b data=%h",
                                          grant, pwdata, req1_ready, req0_ready, e[9:8], e[7:0]);
                    end
                end
            end
        end
        ssptxintr = 0;
        n_cmp++;
        if (writes != 3 * DEPTH) begin n_err++; $display("FAIL contention_count: got %0d writes, want %0d", writes, 3 * DEPTH); end
        n_cmp++;
        if (last != 3 * DEPTH + 2) begin n_err++; $display("FAIL contention_timing: last write at cycle %0d, want %0d", last, 3 * DEPTH + 2); end
        step(); step();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL contention_idle: got busy=%b, want 0", busy); end
        clear_models(); drive();
    endtask

    task automatic test_rx_drain(input int stall);
        int strobes = 0, got = 0, last = -1;
        logic [7:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            rx_src.push_back(8'h10 + 8'(i));
            exp_r.push_back(8'h10 + 8'(i));
        end
        if (stall > 0) begin stall_lo = 6; stall_hi = 5 + stall; end
        ssprxintr = 1; cyc = 0;
        drive();
        for (int i = 0; i < 40 && got < DEPTH; i++) begin
            step();
            if (psel && !pwrite) begin
                strobes++;
                ssprxintr = 0;
            end
            if (rx_valid && !rx_ready) begin
                n_cmp++;
                if (rx_data !== 8'h11 || psel !== 1'b0) begin
                    n_err++; $display("FAIL rx_stall_hold: got rx_data=%h psel=%b, want 11 0", rx_data, psel);
                end
            end
            if (rx_valid && rx_ready) begin
                got++;
                last = cyc;
                e = (exp_r.size() > 0) ? exp_r.pop_front() : 8'hXX;
                n_cmp++;
                if (rx_data !== e) begin n_err++; $display("FAIL rx_data: got %h, want %h", rx_data, e); end
            end
        end
        n_cmp++;
        if (got != DEPTH || strobes != DEPTH) begin
            n_err++; $display("FAIL rx_count: got %0d bytes %0d strobes, want %0d %0d", got, strobes, DEPTH, DEPTH);
        end
        n_cmp++;
        if (last != 3 * DEPTH + stall) begin n_err++; $display("FAIL rx_timing: last byte at cycle %0d, want %0d", last, 3 * DEPTH + stall); end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rx_idle: got busy=%b, want 0", busy); end
        clear_models(); drive();
    endtask

    task automatic test_priority();
        int strobes = 0, writes = 0;
        bit seen = 0;
        logic [9:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            rx_src.push_back(8'h20 + 8'(i));
            exp_r.push_back(8'h20 + 8'(i));
            q0.push_back(8'hB1 + 8'(i));
            exp_w.push_back({2'b01, 8'hB1 + 8'(i)});
        end
        en0 = 1; ssptxintr = 1; ssprxintr = 1; rx_ready = 1; cyc = 0;
        drive();
        for (int i = 0; i < 50 && writes < DEPTH; i++) begin
            step();
            if (psel && !seen) begin
                seen = 1;
                n_cmp++;
                if (pwrite !== 1'b0) begin n_err++; $display("FAIL prio_first: got pwrite=%b, want 0", pwrite); end
            end
            if (psel && !pwrite) begin strobes++; ssprxintr = 0; end
            if (rx_valid && rx_ready) begin
                e = {2'b00, (exp_r.size() > 0) ? exp_r.pop_front() : 8'hXX};
                n_cmp++;
                if (rx_data !== e[7:0]) begin n_err++; $display("FAIL prio_rx: got %h, want %h", rx_data, e[7:0]); end
            end
            if (psel && pwrite) begin
                writes++;
                n_cmp++;
                if (exp_r.size() != 0) begin n_err++; $display("FAIL prio_order: TX write with %0d RX bytes pending, want 0", exp_r.size()); end
                e = (exp_w.size() > 0) ? exp_w.pop_front() : 10'h3FF;
                n_cmp++;
                if ({grant, pwdata} !== e) begin
                    n_err++; $display("FAIL prio_tx: got grant=%b data=%h, want grant=%b data=%h", grant, pwdata, e[9:8], e[7:0]);
                end
            end
        end
        n_cmp++;
        if (writes != DEPTH || strobes != DEPTH) begin
            n_err++; $display("FAIL prio_count: got %0d writes %0d strobes, want %0d %0d", writes, strobes, DEPTH, DEPTH);
        end
        ssptxintr = 0;
        step(); step();
        clear_models(); drive();
    endtask

    task automatic test_midop_reset();
        int writes = 0;
        bit hit = 0;
        logic [9:0] e;
        // Reset while an RX byte is being held.
        for (int i = 0; i < DEPTH; i++) rx_src.push_back(8'h30 + 8'(i));
        stall_lo = 0; stall_hi = 1000; ssprxintr = 1; cyc = 0;
        drive();
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            if (psel && !pwrite) ssprxintr = 0;
            if (rx_valid) hit = 1;
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL midrx_reach: rx_valid never rose, want 1"); end
        #2 clr = 1;
        #1;
        n_cmp++;
        if ({rx_valid, psel, busy, req0_ready, req1_ready} !== 5'd0) begin
            n_err++; $display("FAIL midrx_reset: got rx_valid=%b psel=%b busy=%b rdy=%b%b, want all 0",
                              rx_valid, psel, busy, req1_ready, req0_ready);
        end
        clear_models(); drive();
        step();
        clr = 0;
        // Reset in the middle of a TX burst.
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'hE0 + 8'(i));
            q1.push_back(8'hF0 + 8'(i));
        end
        for (int i = 0; i < 3; i++) exp_w.push_back({2'b01, 8'hE0 + 8'(i)});
        en0 = 1; en1 = 1; ssptxintr = 1;
        drive();
        for (int i = 0; i < 10 && writes < 3; i++) begin
            step();
            if (psel && pwrite) begin
                writes++;
                e = (exp_w.size() > 0) ? exp_w.pop_front() : 10'h3FF;
                n_cmp++;
                if ({grant, pwdata} !== e) begin
                    n_err++; $display("FAIL midtx_write: got grant=%b data=%h, want grant=%b data=%h", grant, pwdata, e[9:8], e[7:0]);
                end
            end
        end
        #2 clr = 1;
        #1;
        n_cmp++;
        if ({psel, req0_ready, req1_ready, grant, busy} !== 6'd0) begin
            n_err++; $display("FAIL midtx_reset: got psel=%b rdy=%b%b grant=%b busy=%b, want all 0",
                              psel, req1_ready, req0_ready, grant, busy);
        end
        step();
        clr = 0;
        drive();
        hit = 0;
        for (int i = 0; i < 5 && !hit; i++) begin
            step();
            if (psel && pwrite) begin
                hit = 1;
                n_cmp++;
                if (grant !== 2'b01) begin n_err++; $display("FAIL midtx_restart: got grant=%b, want 01", grant); end
            end
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL midtx_restart: no write after reset release"); end
        #2 clr = 1;
        clear_models(); drive();
        step();
        clr = 0;
    endtask

    initial begin
        test_reset();
        test_early_end();
        test_contention();
        test_rx_drain(0);
        test_rx_drain(5);
        test_priority();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
